// File: rtl/tile_map_pkg.sv
// Shared types and helpers for the tile map editor: grid defaults, FSM encoding
// and the (h,v) -> walkability bit index mapping.
package tile_map_pkg;

    localparam int HTILES_DEF = 10;
    localparam int VTILES_DEF = 6;
    localparam logic [HTILES_DEF*VTILES_DEF-1:0] DEFAULT_MAP_DEF = {HTILES_DEF*VTILES_DEF{1'b1}};

    typedef enum logic [1:0] {
        LOCKED = 2'd0,
        EDIT   = 2'd1,
        CLEAR  = 2'd2
    } state_e;

    // Row-major: row v occupies bits [v*htiles +: htiles].
    function automatic int tile_index(input int h, input int v, input int htiles);
        return v * htiles + h;
    endfunction

endpackage

// File: rtl/tile_map_editor_cursor_wrap_counter.sv
// One cursor axis: inc/dec pulses step a 0..MAX counter that wraps at both ends.
// Simultaneous inc and dec cancel out.
module cursor_wrap_counter #(
    parameter int MAX = 9
) (
    input  logic       clk1hz,
    input  logic       rst,
    input  logic       en,
    input  logic       inc,
    input  logic       dec,
    output logic [3:0] val
);

    logic [3:0] val_q;
    logic [3:0] val_d;

    always_comb begin
        val_d = val_q;
        if (en && (inc != dec)) begin
            if (inc) begin
                val_d = (val_q == 4'(MAX)) ? 4'd0 : val_q + 4'd1;
            end else begin
                val_d = (val_q == 4'd0) ? 4'(MAX) : val_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk1hz) begin
        if (rst) begin
            val_q <= 4'd0;
        end else begin
            val_q <= val_d;
        end
    end

    assign val = val_q;

endmodule

// File: rtl/tile_map_editor.sv
// Tile walkability map editor driven by slow-tick button pulses; owns the map,
// the edit cursor and the LED row view. Optional build macro: CURSOR_BLINK_EN.
module tile_map_editor
    import tile_map_pkg::*;
#(
    parameter int HTILES = HTILES_DEF,
    parameter int VTILES = VTILES_DEF,
    parameter logic [HTILES*VTILES-1:0] DEFAULT_MAP = {HTILES*VTILES{1'b1}}
) (
    input  logic                     clk1hz,
    input  logic                     rst,
    input  logic                     edit_en,
    input  logic                     up_p,
    input  logic                     down_p,
    input  logic                     left_p,
    input  logic                     right_p,
    input  logic                     toggle_p,
    input  logic                     clear_p,
    input  logic [3:0]               curAh,
    input  logic [3:0]               curAv,
    input  logic [3:0]               curBh,
    input  logic [3:0]               curBv,
    output logic [HTILES*VTILES-1:0] walk_able,
    output logic [3:0]               cur_h,
    output logic [3:0]               cur_v,
    output logic [HTILES-1:0]        row_leds,
    output logic                     busy,
    output logic                     blocked,
    output logic [7:0]               edit_count
);

    localparam int IDX_W = $clog2(HTILES * VTILES);
    localparam int CNT_W = (VTILES > 1) ? $clog2(VTILES) : 1;

    state_e                    state_q, state_d;
    logic [HTILES*VTILES-1:0]  walk_able_q, walk_able_d;
    logic [CNT_W-1:0]          row_cnt_q, row_cnt_d;
    logic [7:0]                edit_count_q, edit_count_d;
    logic                      blocked_q, blocked_d;

    logic                      move_en;
    logic [IDX_W-1:0]          cur_idx;
    logic                      cur_tile;
    logic                      hit_a;
    logic                      hit_b;

    // Moves are suppressed in the cycle a clear is accepted.
    assign move_en = (state_q == EDIT) && edit_en && !clear_p;

    cursor_wrap_counter #(.MAX(HTILES - 1)) u_cur_h (
        .clk1hz (clk1hz),
        .rst    (rst),
        .en     (move_en),
        .inc    (right_p),
        .dec    (left_p),
        .val    (cur_h)
    );

    cursor_wrap_counter #(.MAX(VTILES - 1)) u_cur_v (
        .clk1hz (clk1hz),
        .rst    (rst),
        .en     (move_en),
        .inc    (down_p),
        .dec    (up_p),
        .val    (cur_v)
    );

    assign cur_idx  = IDX_W'(tile_index(int'(cur_h), int'(cur_v), HTILES));
    assign cur_tile = walk_able_q[cur_idx];
    assign hit_a    = (curAh == cur_h) && (curAv == cur_v);
    assign hit_b    = (curBh == cur_h) && (curBv == cur_v);

    always_comb begin
        state_d      = state_q;
        walk_able_d  = walk_able_q;
        row_cnt_d    = row_cnt_q;
        edit_count_d = edit_count_q;
        blocked_d    = 1'b0;
        case (state_q)
            LOCKED: begin
                if (edit_en) state_d = EDIT;
            end
            EDIT: begin
                if (!edit_en) begin
                    state_d = LOCKED;
                end else if (clear_p) begin
                    state_d   = CLEAR;
                    row_cnt_d = '0;
                end else if (toggle_p) begin
                    // Blocking a tile under a player is refused; unblocking is always fine.
                    if (cur_tile && (hit_a || hit_b)) begin
                        blocked_d = 1'b1;
                    end else begin
                        walk_able_d[cur_idx] = ~cur_tile;
                        if (edit_count_q != 8'hFF) edit_count_d = edit_count_q + 8'd1;
                    end
                end
            end
            CLEAR: begin
                for (int h = 0; h < HTILES; h++) begin
                    walk_able_d[IDX_W'(tile_index(h, int'(row_cnt_q), HTILES))] =
                        DEFAULT_MAP[IDX_W'(tile_index(h, int'(row_cnt_q), HTILES))];
                end
                if (row_cnt_q == CNT_W'(VTILES - 1)) begin
                    edit_count_d = 8'd0;
                    state_d      = edit_en ? EDIT : LOCKED;
                end else begin
                    row_cnt_d = row_cnt_q + 1'b1;
                end
            end
            default: state_d = LOCKED;
        endcase
    end

    always_ff @(posedge clk1hz) begin
        if (rst) begin
            state_q      <= LOCKED;
            walk_able_q  <= DEFAULT_MAP;
            row_cnt_q    <= '0;
            edit_count_q <= 8'd0;
            blocked_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            walk_able_q  <= walk_able_d;
            row_cnt_q    <= row_cnt_d;
            edit_count_q <= edit_count_d;
            blocked_q    <= blocked_d;
        end
    end

`ifdef CURSOR_BLINK_EN
    logic blink_q, blink_d;

    assign blink_d = ~blink_q;

    always_ff @(posedge clk1hz) begin
        if (rst) begin
            blink_q <= 1'b0;
        end else begin
            blink_q <= blink_d;
        end
    end

    always_comb begin
        row_leds = '0;
        for (int h = 0; h < HTILES; h++) begin
            row_leds[h] = walk_able_q[IDX_W'(tile_index(h, int'(cur_v), HTILES))];
            if (4'(h) == cur_h) row_leds[h] = row_leds[h] ^ blink_q;
        end
    end
`else
    always_comb begin
        row_leds = '0;
        for (int h = 0; h < HTILES; h++) begin
            row_leds[h] = walk_able_q[IDX_W'(tile_index(h, int'(cur_v), HTILES))];
        end
    end
`endif

    assign walk_able  = walk_able_q;
    assign busy       = (state_q == CLEAR);
    assign blocked    = blocked_q;
    assign edit_count = edit_count_q;

endmodule

// File: tb/tb_tile_map_editor.sv
// Directed self-checking bench for tile_map_editor (default parameters, blink disabled).
module tb_tile_map_editor;

    localparam logic [59:0] ALL_ONES = {60{1'b1}};

    logic        clk1hz = 1'b0;
    logic        rst;
    logic        edit_en;
    logic        up_p, down_p, left_p, right_p, toggle_p, clear_p;
    logic [3:0]  curAh, curAv, curBh, curBv;
    logic [59:0] walk_able;
    logic [3:0]  cur_h, cur_v;
    logic [9:0]  row_leds;
    logic        busy;
    logic        blocked;
    logic [7:0]  edit_count;

    int assert_cnt = 0;
    int fail_cnt   = 0;

    tile_map_editor dut (
        .clk1hz     (clk1hz),
        .rst        (rst),
        .edit_en    (edit_en),
        .up_p       (up_p),
        .down_p     (down_p),
        .left_p     (left_p),
        .right_p    (right_p),
        .toggle_p   (toggle_p),
        .clear_p    (clear_p),
        .curAh      (curAh),
        .curAv      (curAv),
        .curBh      (curBh),
        .curBv      (curBv),
        .walk_able  (walk_able),
        .cur_h      (cur_h),
        .cur_v      (cur_v),
        .row_leds   (row_leds),
        .busy       (busy),
        .blocked    (blocked),
        .edit_count (edit_count)
    );

    always #5 clk1hz = ~clk1hz;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        assert_cnt++;
        if (obs !== exp_v) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk1hz);
        #1;
    endtask

    // Drive a pulse set for one clock, then release everything.
    task automatic pulse(input logic u, input logic d, input logic l, input logic r,
                         input logic t, input logic c);
        up_p = u; down_p = d; left_p = l; right_p = r; toggle_p = t; clear_p = c;
        tick();
        up_p = 0; down_p = 0; left_p = 0; right_p = 0; toggle_p = 0; clear_p = 0;
    endtask

    int n;

    initial begin
        rst = 1; edit_en = 0;
        up_p = 0; down_p = 0; left_p = 0; right_p = 0; toggle_p = 0; clear_p = 0;
        curAh = 4'hF; curAv = 4'hF; curBh = 4'hF; curBv = 4'hF;
        tick(); tick();
        rst = 0;

        check_eq("rst_map",   64'(walk_able), 64'(ALL_ONES));
        check_eq("rst_cur_h", 64'(cur_h), 64'd0);
        check_eq("rst_cur_v", 64'(cur_v), 64'd0);
        check_eq("rst_leds",  64'(row_leds), 64'h3FF);
        check_eq("rst_busy",  64'(busy), 64'd0);
        check_eq("rst_count", 64'(edit_count), 64'd0);
        check_eq("rst_blk",   64'(blocked), 64'd0);

        pulse(0, 0, 0, 1, 0, 0);
        check_eq("locked_move", 64'(cur_h), 64'd0);

        edit_en = 1;
        tick();
        pulse(0, 0, 1, 0, 0, 0);
        check_eq("wrap_left",  64'(cur_h), 64'd9);
        pulse(1, 0, 0, 0, 0, 0);
        check_eq("wrap_up",    64'(cur_v), 64'd5);
        pulse(0, 1, 0, 0, 0, 0);
        check_eq("wrap_down",  64'(cur_v), 64'd0);
        pulse(0, 0, 0, 1, 0, 0);
        check_eq("wrap_right", 64'(cur_h), 64'd0);
        pulse(1, 1, 1, 1, 0, 0);
        check_eq("cancel_h", 64'(cur_h), 64'd0);
        check_eq("cancel_v", 64'(cur_v), 64'd0);

        for (int i = 0; i < 3; i++) pulse(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 2; i++) pulse(0, 1, 0, 0, 0, 0);
        check_eq("pos_h", 64'(cur_h), 64'd3);
        check_eq("pos_v", 64'(cur_v), 64'd2);

        pulse(0, 0, 0, 0, 1, 0);
        check_eq("tog1_bit",   64'(walk_able[23]), 64'd0);
        check_eq("tog1_count", 64'(edit_count), 64'd1);
        check_eq("tog1_leds",  64'(row_leds), 64'h3F7);
        pulse(0, 0, 0, 0, 1, 0);
        check_eq("tog2_bit",   64'(walk_able[23]), 64'd1);
        check_eq("tog2_count", 64'(edit_count), 64'd2);

        curAh = 4'd3; curAv = 4'd2;
        pulse(0, 0, 0, 0, 1, 0);
        check_eq("blkA_bit",   64'(walk_able[23]), 64'd1);
        check_eq("blkA_pulse", 64'(blocked), 64'd1);
        check_eq("blkA_count", 64'(edit_count), 64'd2);
        tick();
        check_eq("blk_drop",   64'(blocked), 64'd0);

        curAh = 4'hF; curAv = 4'hF; curBh = 4'd3; curBv = 4'd2;
        pulse(0, 0, 0, 0, 1, 0);
        check_eq("blkB_pulse", 64'(blocked), 64'd1);
        check_eq("blkB_map",   64'(walk_able), 64'(ALL_ONES));

        curBh = 4'hF; curBv = 4'hF;
        pulse(0, 0, 0, 0, 1, 0);
        check_eq("tog3_bit", 64'(walk_able[23]), 64'd0);
        curBh = 4'd3; curBv = 4'd2;
        pulse(0, 0, 0, 0, 1, 0);
        check_eq("unblk_bit",   64'(walk_able[23]), 64'd1);
        check_eq("unblk_pulse", 64'(blocked), 64'd0);
        check_eq("unblk_count", 64'(edit_count), 64'd4);
        curBh = 4'hF; curBv = 4'hF;

        // Toggle with a coincident move acts on the old cursor tile.
        pulse(0, 0, 0, 1, 1, 0);
        check_eq("premove_bit23", 64'(walk_able[23]), 64'd0);
        check_eq("premove_bit24", 64'(walk_able[24]), 64'd1);
        check_eq("premove_h",     64'(cur_h), 64'd4);
        check_eq("premove_count", 64'(edit_count), 64'd5);

        for (int i = 0; i < 260; i++) pulse(0, 0, 0, 0, 1, 0);
        check_eq("sat_count", 64'(edit_count), 64'd255);
        check_eq("sat_bit24", 64'(walk_able[24]), 64'd1);

        // Clear takes precedence over a coincident move and toggle.
        pulse(0, 0, 0, 1, 1, 1);
        check_eq("clr_h", 64'(cur_h), 64'd4);
        n = 0;
        while (busy && n < 20) begin
            n++;
            tick();
        end
        check_eq("clr_busy_len", 64'(n), 64'd6);
        check_eq("clr_map",      64'(walk_able), 64'(ALL_ONES));
        check_eq("clr_count",    64'(edit_count), 64'd0);
        pulse(0, 0, 0, 0, 1, 0);
        check_eq("clr_edit_bit",   64'(walk_able[24]), 64'd0);
        check_eq("clr_edit_count", 64'(edit_count), 64'd1);

        pulse(0, 0, 0, 0, 0, 1);
        check_eq("clr2_busy", 64'(busy), 64'd1);
        tick(); tick();
        rst = 1;
        tick();
        rst = 0;
        edit_en = 0;
        check_eq("midclr_busy",  64'(busy), 64'd0);
        check_eq("midclr_map",   64'(walk_able), 64'(ALL_ONES));
        check_eq("midclr_cur",   64'({cur_h, cur_v}), 64'd0);
        check_eq("midclr_count", 64'(edit_count), 64'd0);

        pulse(0, 0, 0, 0, 1, 0);
        check_eq("locked_tog", 64'(walk_able), 64'(ALL_ONES));
        edit_en = 1;
        tick();
        edit_en = 0;
        pulse(0, 0, 0, 0, 1, 0);
        check_eq("disabled_tog_map",   64'(walk_able), 64'(ALL_ONES));
        check_eq("disabled_tog_count", 64'(edit_count), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
